// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and fetch-handshake bundle for pc_sequencer.
//   slave  modport : used by pc_sequencer (takes control/ready, drives pc/status)
//   master modport : used by the CPU control unit / ROM side
//   Control in : start, soft_reset, load, load_addr[15:0], stall, halt_req
//   Fetch       : fetch_ready (in), pc[15:0] (out), fetch_valid (out)
//   Status out  : halted, wrapped, state[1:0]
interface pc_sequencer_if;
    logic        start;
    logic        soft_reset;
    logic        load;
    logic [15:0] load_addr;
    logic        stall;
    logic        halt_req;
    logic        fetch_ready;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        halted;
    logic        wrapped;
    logic [1:0]  state;

    modport slave (
        input  start, soft_reset, load, load_addr, stall, halt_req, fetch_ready,
        output pc, fetch_valid, halted, wrapped, state
    );

    modport master (
        output start, soft_reset, load, load_addr, stall, halt_req, fetch_ready,
        input  pc, fetch_valid, halted, wrapped, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: Hack CPU program-counter controller for the fetch path.
//   Owns the 16-bit PC, advances it through an Inc16 instance on every
//   accepted fetch (fetch_valid & fetch_ready), and handles branch load,
//   stall, halt/resume and synchronous soft restart.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : pc_sequencer_if.slave (control inputs, ROM handshake, status)
//   Parameter RESET_ADDR: PC value after hard or soft reset.

// Inc16: 16-bit incrementer, modulo 2^16.
module Inc16 (
    input  logic [15:0] in_i,
    output logic [15:0] out_o
);
    assign out_o = in_i + 16'd1;
endmodule

module pc_sequencer #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        wrapped_q, wrapped_d;
    logic [15:0] pc_inc;
    logic        accept;

    Inc16 u_inc16 (
        .in_i  (pc_q),
        .out_o (pc_inc)
    );

    // Outputs decode the state register only: no input-to-output path.
    assign bus.fetch_valid = (state_q == ST_RUN);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.state       = state_q;
    assign bus.pc          = pc_q;
    assign bus.wrapped     = wrapped_q;

    assign accept = (state_q == ST_RUN) && bus.fetch_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = wrapped_q;

        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.halt_req)   state_d = ST_HALT;
                else if (bus.stall) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.halt_req)    state_d = ST_HALT;
                else if (!bus.stall) state_d = ST_RUN;
            end
            ST_HALT: if (bus.start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        // A load wins over an accept: the outstanding fetch is squashed
        // and the new target is presented on the next cycle.
        if (bus.load) begin
            pc_d = bus.load_addr;
        end else if (accept) begin
            pc_d = pc_inc;
            if (pc_q == 16'hFFFF) wrapped_d = 1'b1;
        end

        if (bus.soft_reset) begin
            state_d   = ST_IDLE;
            pc_d      = RESET_ADDR;
            wrapped_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_ADDR;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
//   Directed scenarios for reset, sequential fetch, branch, arithmetic
//   boundaries, stall/halt and async reset, followed by randomized
//   stimulus. A behavioural model tracks the expected PC, mode and
//   wrap flag using plain integer arithmetic.
module tb_pc_sequencer;

    localparam int unsigned RESET_ADDR = 0;

    logic clk;
    logic rst_n;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_ADDR(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass;
    int unsigned n_total;

    // Reference model: mode 0=idle,1=run,2=wait,3=halt
    int unsigned m_pc;
    int unsigned m_mode;
    int unsigned m_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        check("pc",          {16'd0, bus.pc},          m_pc);
        check("fetch_valid", {31'd0, bus.fetch_valid}, (m_mode == 1) ? 1 : 0);
        check("halted",      {31'd0, bus.halted},      (m_mode == 3) ? 1 : 0);
        check("state",       {30'd0, bus.state},       m_mode);
        check("wrapped",     {31'd0, bus.wrapped},     m_wr);
    endtask

    task automatic model_reset();
        m_pc = RESET_ADDR; m_mode = 0; m_wr = 0;
    endtask

    // Advance the model using the inputs currently applied, clock the DUT,
    // then compare shortly after the edge.
    task automatic step();
        bit fetched;
        int unsigned nxt;
        fetched = (m_mode == 1) && bus.fetch_ready;
        nxt = m_mode;
        case (m_mode)
            0: if (bus.start) nxt = 1;
            1: nxt = bus.halt_req ? 3 : (bus.stall ? 2 : 1);
            2: nxt = bus.halt_req ? 3 : (bus.stall ? 2 : 1);
            default: if (bus.start) nxt = 1;
        endcase
        if (bus.soft_reset) begin
            m_pc = RESET_ADDR; m_wr = 0; nxt = 0;
        end else if (bus.load) begin
            m_pc = bus.load_addr;
        end else if (fetched) begin
            if (m_pc == 65535) m_wr = 1;
            m_pc = (m_pc + 1) % 65536;
        end
        m_mode = nxt;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.soft_reset = 0; bus.load = 0; bus.load_addr = '0;
        bus.stall = 0; bus.halt_req = 0; bus.fetch_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        idle_inputs();
        model_reset();

        // Reset values
        rst_n = 0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) step();

        // Sequential fetch
        bus.start = 1; step();
        bus.start = 0; bus.fetch_ready = 1;
        for (int i = 0; i < 4; i++) step();
        check("seq_pc4", {16'd0, bus.pc}, 4);
        bus.fetch_ready = 0;
        for (int i = 0; i < 2; i++) step();
        check("hold_pc4", {16'd0, bus.pc}, 4);

        // Branch from pc=5
        bus.fetch_ready = 1; step();
        bus.fetch_ready = 0; bus.load = 1; bus.load_addr = 16'h0100; step();
        check("branch_pc", {16'd0, bus.pc}, 32'h100);
        bus.load = 0; bus.fetch_ready = 1; step();
        check("branch_inc", {16'd0, bus.pc}, 32'h101);

        // Arithmetic boundaries
        bus.fetch_ready = 0; bus.load = 1; bus.load_addr = 16'h7FFF; step();
        bus.load = 0; bus.fetch_ready = 1; step();
        check("pc_8000", {16'd0, bus.pc}, 32'h8000);
        check("no_wrap", {31'd0, bus.wrapped}, 0);
        bus.fetch_ready = 0; bus.load = 1; bus.load_addr = 16'hFFFF; step();
        bus.load = 0; bus.fetch_ready = 1; step();
        check("pc_wrap", {16'd0, bus.pc}, 0);
        check("wrap_set", {31'd0, bus.wrapped}, 1);
        bus.fetch_ready = 0; step();
        check("wrap_sticky", {31'd0, bus.wrapped}, 1);
        bus.soft_reset = 1; step();
        bus.soft_reset = 0;
        check("soft_wrap", {31'd0, bus.wrapped}, 0);
        check("soft_state", {30'd0, bus.state}, 0);

        // Stall with fetch_ready held high
        bus.start = 1; step();
        bus.start = 0; bus.fetch_ready = 1; bus.stall = 1; step();
        step();
        check("wait_state", {30'd0, bus.state}, 2);
        check("wait_pc", {16'd0, bus.pc}, 1);
        bus.stall = 0; step();
        step();
        check("resume_pc", {16'd0, bus.pc}, 2);

        // Halt with accept at pc=9
        bus.fetch_ready = 0; bus.load = 1; bus.load_addr = 16'd9; step();
        bus.load = 0; bus.halt_req = 1; bus.fetch_ready = 1; step();
        check("halt_pc", {16'd0, bus.pc}, 10);
        check("halt_state", {30'd0, bus.state}, 3);
        bus.halt_req = 0; bus.start = 1; step();
        bus.start = 0; bus.fetch_ready = 0;
        check("resume_state", {30'd0, bus.state}, 1);
        check("resume_at", {16'd0, bus.pc}, 10);

        // Async reset between edges
        bus.load = 1; bus.load_addr = 16'h0042; step();
        bus.load = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("async_pc", {16'd0, bus.pc}, 0);
        check("async_fv", {31'd0, bus.fetch_valid}, 0);
        #3;
        rst_n = 1;
        @(negedge clk);

        // Randomized
        for (int i = 0; i < 400; i++) begin
            bus.soft_reset  = ($urandom_range(31) == 0);
            bus.load        = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0: bus.load_addr = 16'hFFFF;
                1: bus.load_addr = 16'hFFFD;
                default: bus.load_addr = 16'($urandom);
            endcase
            bus.start       = ($urandom_range(3) == 0);
            bus.stall       = ($urandom_range(3) == 0);
            bus.halt_req    = ($urandom_range(15) == 0);
            bus.fetch_ready = ($urandom_range(1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the Hack CPU fetch path.
- Owns the 16-bit PC register and sequences the shared Inc16 datapath, which is instantiated inside this block, to advance it.
- Performs a valid/ready fetch handshake with instruction ROM; handles branch load, stall, halt/resume and soft restart.
- Sits between the CPU control unit (load/stall/halt) and ROM32K address input.

Parameters:
- RESET_ADDR, 16'h0000, PC value after hard or soft reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE/HALT and begin or resume fetching.
- soft_reset  input  1  synchronous restart: PC to RESET_ADDR, go IDLE.
- load  input  1  branch taken; PC takes load_addr.
- load_addr  input  16  branch target.
- stall  input  1  pipeline stall request.
- halt_req  input  1  stop fetching.
- fetch_ready  input  1  ROM accepts current address.
- pc  output  16  current fetch address (registered).
- fetch_valid  output  1  pc is a valid fetch request.
- halted  output  1  high in HALT.
- wrapped  output  1  sticky flag: PC incremented from 16'hFFFF to 16'h0000.
- state  output  2  IDLE=0, RUN=1, WAIT=2, HALT=3.

Behaviour:
- Reset: rst_n low asynchronously sets pc=RESET_ADDR, state=IDLE, wrapped=0. fetch_valid=0 and halted=0 follow from state.
- All other updates occur on the rising clk edge.
- fetch_valid = (state==RUN). halted = (state==HALT). Both are decoded from the state register, so no combinational input-to-output path exists.
- accept = fetch_valid & fetch_ready.
- PC update priority:
  1. soft_reset: pc=RESET_ADDR.
  2. load: pc=load_addr, in any state.
  3. accept: pc=Inc16(pc).
  4. Otherwise hold.
- Increment is modulo 2^16, taken from the Inc16 instance. 16'h7FFF→16'h8000 with no special case. 16'hFFFF→16'h0000 sets wrapped. wrapped clears only on rst_n or soft_reset.
- A load in RUN without accept squashes the outstanding fetch. fetch_valid stays high and presents the new pc next cycle. Latency from load to new address on pc is 1 cycle.
- State transitions (soft_reset overrides all, forcing IDLE):
  - IDLE: start→RUN; else stay. pc holds unless load.
  - RUN:
    - halt_req→HALT. Any accept in the same cycle still completes and pc still advances.
    - Else stall→WAIT. Accept in that cycle still completes.
    - Else stay RUN.
  - WAIT: fetch_valid=0, no increment.
    - halt_req→HALT.
    - Else !stall→RUN.
    - Else stay WAIT.
    - load is honoured (branch resolved during stall).
  - HALT: start→RUN, resuming at the current pc; else stay. load is honoured (debugger PC write).
- start in RUN/WAIT is ignored. halt_req in IDLE/HALT is ignored.
- Transaction ordering: every accepted address appears exactly once. No address is skipped except by load or soft_reset.
- rst_n asserted mid-handshake abandons the fetch immediately; fetch_valid drops combinationally with the state register.

Test Plan:
- Reset values: hold rst_n=0 → pc=16'h0000, fetch_valid=0, state=0, wrapped=0. Release, wait 3 cycles without start → values unchanged.
- Sequential fetch: start pulse, then fetch_ready=1 for 4 cycles → pc sequence 0,1,2,3,4 with fetch_valid=1. With fetch_ready=0 for 2 cycles → pc holds.
- Branch: in RUN with pc=5, fetch_ready=0, load=1, load_addr=16'h0100 → next cycle pc=16'h0100 and fetch_valid=1. Then accept → pc=16'h0101.
- Arithmetic boundaries:
  - load 16'h7FFF, then accept → pc=16'h8000 (signed 32767→-32768), wrapped=0.
  - load 16'hFFFF, then accept → pc=16'h0000, wrapped=1.
  - soft_reset → wrapped=0, state=IDLE.
- Stall/halt:
  - stall for 2 cycles with fetch_ready=1 → state=2, fetch_valid=0, pc frozen. Release → RUN, increments resume.
  - halt_req together with accept at pc=9 → pc=10, state=3, halted=1. start → RUN at pc=10.
- Async reset mid-run: at pc=16'h0042 in RUN, drop rst_n between clock edges → pc=RESET_ADDR and fetch_valid=0 before the next edge.
